wb_stream_port: RTL and testbench
=================================

WB_STREAM_PORT -- requirements
Module: wb_stream_port

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 The block SHALL have parameter ABITS, default 3, Wishbone address width; the address is accepted and ignored.
REQ-003 The block SHALL have parameter DEPTH, default 4, buffer depth in words; DEPTH is a power of two and at least 2.
REQ-004 The block SHALL have parameter DELAY, default 3, simulation-only intra-assignment delay on registered outputs.
REQ-005 The block SHALL have port clk_i, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-006 The block SHALL have port rst_i, input, 1 bit; reset is asynchronous and active-high.
REQ-007 The block SHALL have Wishbone responder ports: cyc_i, stb_i, we_i (input, 1 bit each); adr_i (input, ABITS bits); dat_i (input, WIDTH bits).
REQ-008 The block SHALL have Wishbone responder outputs: ack_o, wat_o, rty_o, err_o (output, 1 bit each); dat_o (output, WIDTH bits).
REQ-009 The block SHALL have stream source ports: s_valid_i (input, 1 bit); s_data_i (input, WIDTH bits); s_ready_o (output, 1 bit); clear_i (input, 1 bit, synchronous buffer flush).

Function
REQ-010 The block SHALL buffer stream words in a DEPTH-entry FIFO; a push occurs when s_valid_i && s_ready_o.
REQ-011 s_ready_o SHALL be registered and high iff the post-update occupancy is < DEPTH.
REQ-012 wat_o SHALL be high iff occupancy == 0; it is derived only from the registered count, with no combinational path from the Wishbone inputs.
REQ-013 A read SHALL be accepted when cyc_i && stb_i && !we_i && !wat_o; acceptance pops the FIFO head.
REQ-014 For an accepted read, the block SHALL assert ack_o for exactly one cycle on the next edge, with dat_o = the popped word; latency is 1 cycle and one read can be accepted per cycle (pipelined burst).
REQ-015 dat_o SHALL hold its last value whenever ack_o is low.
REQ-016 A write (cyc_i && stb_i && we_i) SHALL be rejected: no pop, err_o high for one cycle on the next edge, and dat_i discarded; a write is accepted even while wat_o is high.
REQ-017 rty_o SHALL be held constantly low.
REQ-018 If cyc_i is low on the cycle ack_o or err_o would assert, that response SHALL be suppressed; a popped word is then discarded and not restored.
REQ-019 On a simultaneous push and pop, occupancy SHALL be unchanged, with the pushed word written behind the popped head; push-at-full and pop-at-empty are impossible by REQ-011 and REQ-012.
REQ-020 Read and write pointers SHALL wrap modulo DEPTH; occupancy uses log2(DEPTH)+1 bits.
REQ-021 clear_i SHALL empty the FIFO on the next edge, with priority over any push or pop in the same cycle; a read accepted in that cycle is still acknowledged with the old head.
REQ-022 ack_o and err_o SHALL never be high in the same cycle.

Reset
REQ-023 Asserting rst_i SHALL immediately force: ack_o=0, err_o=0, rty_o=0, dat_o=0, s_ready_o=0, occupancy=0 (so wat_o=1), and both pointers 0.
REQ-024 s_ready_o SHALL rise on the first clock edge after rst_i deasserts.
REQ-025 Reset mid-burst SHALL discard buffered data and any pending response without emitting a spurious ack_o.

Structure
REQ-026 The FIFO (storage, pointers, count) SHALL be a sub-module named wb_stream_fifo with a synchronous clear input.
REQ-027 Wishbone response-signal widths and the log2 helper SHALL live in the shared Wishbone include/package, not in this block.

Verification
REQ-028 Reset, then push 0x11,0x22,0x33,0x44 -> s_ready_o=0 after the 4th push; wat_o=0; occupancy 4.
REQ-029 With 4 buffered words, issue a 4-beat pipelined read burst -> ack_o high on 4 consecutive cycles with dat_o 0x11,0x22,0x33,0x44; wat_o=1 afterwards.
REQ-030 Empty FIFO, hold cyc/stb read -> wat_o=1 and no ack_o; push 0xA5 -> ack_o one cycle after the acceptance cycle with dat_o=0xA5.
REQ-031 Write request with dat_i=0xDEADBEEF -> err_o for one cycle; occupancy unchanged; ack_o stays 0.
REQ-032 FIFO full, simultaneous read and push of 0x55 -> s_ready_o stays 0; after draining, 0x55 appears last with correct wrap ordering.
REQ-033 Assert rst_i asynchronously mid-burst and, separately, clear_i with 3 words buffered -> outputs take reset values at once, and wat_o=1 on the next edge respectively.

Source files
------------

// File: rtl/wb_stream_port_pkg.sv
`default_nettype none
// ============================================================================
// wb_stream_port_pkg : shared Wishbone response type and log2 helper
// Rev 1.0
// ============================================================================
package wb_stream_port_pkg;

    typedef struct packed {
        logic ack;
        logic err;
    } wb_rsp_t;

    function automatic int log2c(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_stream_fifo.sv
`default_nettype none
// ============================================================================
// wb_stream_fifo : DEPTH-entry word FIFO with synchronous clear
// Rev 1.0
// ============================================================================
module wb_stream_fifo
    import wb_stream_port_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        data_i,
    input  logic                    pop_i,
    output logic [WIDTH-1:0]        head_o,
    output logic [log2c(DEPTH):0]   count_o,
    output logic [log2c(DEPTH):0]   count_next_o
);

    localparam int AW = log2c(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;

    // Clear wins over any concurrent push or pop; pointers wrap by width.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clear_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) wptr_d = wptr_q + AW'(1);
            if (pop_i)  rptr_d = rptr_q + AW'(1);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !clear_i) mem_q[wptr_q] <= data_i;
    end

    assign head_o       = mem_q[rptr_q];
    assign count_o      = count_q;
    assign count_next_o = count_d;

endmodule
`default_nettype wire

// File: rtl/wb_stream_port.sv
`default_nettype none
// ============================================================================
// wb_stream_port : Wishbone read-only responder draining a buffered stream
// Rev 1.0
// ============================================================================
module wb_stream_port
    import wb_stream_port_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ABITS = 3,
    parameter int DEPTH = 4,
    parameter int DELAY = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cyc_i,
    input  logic             stb_i,
    input  logic             we_i,
    input  logic [ABITS-1:0] adr_i,
    input  logic [WIDTH-1:0] dat_i,
    output logic             ack_o,
    output logic             wat_o,
    output logic             rty_o,
    output logic             err_o,
    output logic [WIDTH-1:0] dat_o,
    input  logic             s_valid_i,
    input  logic [WIDTH-1:0] s_data_i,
    output logic             s_ready_o,
    input  logic             clear_i
);

    localparam int CW = log2c(DEPTH) + 1;
    // DELAY applies to behavioural simulation models only; these registers carry no delay.
    localparam int c_unused_delay = DELAY;

    logic             w_unused_inputs;
    logic             w_rd, w_wr, w_push;
    logic [CW-1:0]    w_count, w_count_next;
    logic [WIDTH-1:0] w_head;
    wb_rsp_t          rsp_q, rsp_d;
    logic             s_ready_q, s_ready_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [WIDTH-1:0] dat_q, dat_d;

    assign w_unused_inputs = ^{adr_i, dat_i};

    assign wat_o  = (w_count == '0);
    assign w_rd   = cyc_i & stb_i & ~we_i & ~wat_o;
    assign w_wr   = cyc_i & stb_i & we_i;
    assign w_push = s_valid_i & s_ready_q;

    wb_stream_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (clear_i),
        .push_i       (w_push),
        .data_i       (s_data_i),
        .pop_i        (w_rd),
        .head_o       (w_head),
        .count_o      (w_count),
        .count_next_o (w_count_next)
    );

    // dat_q tracks the last word actually delivered, so a response that is
    // suppressed by a dropped cycle never leaks onto dat_o.
    always_comb begin
        rsp_d     = '0;
        rsp_d.ack = w_rd;
        rsp_d.err = w_wr;
        rdata_d   = w_rd ? w_head : rdata_q;
        dat_d     = ack_o ? rdata_q : dat_q;
        s_ready_d = (w_count_next < CW'(DEPTH));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_q     <= '0;
            s_ready_q <= 1'b0;
            rdata_q   <= '0;
            dat_q     <= '0;
        end else begin
            rsp_q     <= rsp_d;
            s_ready_q <= s_ready_d;
            rdata_q   <= rdata_d;
            dat_q     <= dat_d;
        end
    end

    assign ack_o     = rsp_q.ack & cyc_i;
    assign err_o     = rsp_q.err & cyc_i;
    assign rty_o     = 1'b0;
    assign dat_o     = ack_o ? rdata_q : dat_q;
    assign s_ready_o = s_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_stream_port.sv
`default_nettype none
// ============================================================================
// tb_wb_stream_port : directed self-checking bench for wb_stream_port
// Rev 1.0
// ============================================================================
module tb_wb_stream_port;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
    logic [2:0]  adr_i = '0;
    logic [31:0] dat_i = '0;
    logic        ack_o, wat_o, rty_o, err_o;
    logic [31:0] dat_o;
    logic        s_valid_i = 1'b0;
    logic [31:0] s_data_i = '0;
    logic        s_ready_o;
    logic        clear_i = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    wb_stream_port dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .cyc_i     (cyc_i),
        .stb_i     (stb_i),
        .we_i      (we_i),
        .adr_i     (adr_i),
        .dat_i     (dat_i),
        .ack_o     (ack_o),
        .wat_o     (wat_o),
        .rty_o     (rty_o),
        .err_o     (err_o),
        .dat_o     (dat_o),
        .s_valid_i (s_valid_i),
        .s_data_i  (s_data_i),
        .s_ready_o (s_ready_o),
        .clear_i   (clear_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no finish want finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        s_valid_i = 1'b1;
        s_data_i  = w;
        step();
        s_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        #2;
        n_tests++; if (ack_o !== 1'b0)     begin n_fail++; $display("FAIL rst_ack: got %b want 0", ack_o); end
        n_tests++; if (err_o !== 1'b0)     begin n_fail++; $display("FAIL rst_err: got %b want 0", err_o); end
        n_tests++; if (rty_o !== 1'b0)     begin n_fail++; $display("FAIL rst_rty: got %b want 0", rty_o); end
        n_tests++; if (dat_o !== 32'h0)    begin n_fail++; $display("FAIL rst_dat: got %h want 0", dat_o); end
        n_tests++; if (s_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", s_ready_o); end
        n_tests++; if (wat_o !== 1'b1)     begin n_fail++; $display("FAIL rst_wat: got %b want 1", wat_o); end
        step();
        rst_i = 1'b0;
        #1;
        n_tests++; if (s_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_ready_pre: got %b want 0", s_ready_o); end
        step();
        n_tests++; if (s_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready_rise: got %b want 1", s_ready_o); end
        n_tests++; if (wat_o !== 1'b1)     begin n_fail++; $display("FAIL rst_wat_after: got %b want 1", wat_o); end
    endtask

    task automatic test_fill();
        logic [31:0] words [4];
        words = '{32'h11, 32'h22, 32'h33, 32'h44};
        for (int i = 0; i < 4; i++) begin
            push_word(words[i]);
            n_tests++;
            if (s_ready_o !== (i < 3)) begin n_fail++; $display("FAIL fill_ready[%0d]: got %b want %b", i, s_ready_o, (i < 3)); end
        end
        n_tests++; if (wat_o !== 1'b0)          begin n_fail++; $display("FAIL fill_wat: got %b want 0", wat_o); end
        n_tests++; if (dut.w_count !== 3'd4)    begin n_fail++; $display("FAIL fill_count: got %0d want 4", dut.w_count); end
    endtask

    task automatic test_burst();
        logic [31:0] exp [4];
        exp = '{32'h11, 32'h22, 32'h33, 32'h44};
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            n_tests++; if (ack_o !== 1'b1)  begin n_fail++; $display("FAIL burst_ack[%0d]: got %b want 1", k, ack_o); end
            n_tests++; if (dat_o !== exp[k]) begin n_fail++; $display("FAIL burst_dat[%0d]: got %h want %h", k, dat_o, exp[k]); end
        end
        step();
        n_tests++; if (ack_o !== 1'b0)     begin n_fail++; $display("FAIL burst_ack_end: got %b want 0", ack_o); end
        n_tests++; if (wat_o !== 1'b1)     begin n_fail++; $display("FAIL burst_wat: got %b want 1", wat_o); end
        n_tests++; if (dat_o !== 32'h44)   begin n_fail++; $display("FAIL burst_hold: got %h want 44", dat_o); end
        n_tests++; if (s_ready_o !== 1'b1) begin n_fail++; $display("FAIL burst_ready: got %b want 1", s_ready_o); end
        cyc_i = 1'b0; stb_i = 1'b0;
    endtask

    task automatic test_wait();
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            n_tests++; if (ack_o !== 1'b0) begin n_fail++; $display("FAIL wait_ack[%0d]: got %b want 0", k, ack_o); end
            n_tests++; if (wat_o !== 1'b1) begin n_fail++; $display("FAIL wait_wat[%0d]: got %b want 1", k, wat_o); end
        end
        push_word(32'hA5);
        n_tests++; if (ack_o !== 1'b0)   begin n_fail++; $display("FAIL wait_accept_ack: got %b want 0", ack_o); end
        step();
        n_tests++; if (ack_o !== 1'b1)   begin n_fail++; $display("FAIL wait_ack_a5: got %b want 1", ack_o); end
        n_tests++; if (dat_o !== 32'hA5) begin n_fail++; $display("FAIL wait_dat_a5: got %h want a5", dat_o); end
        n_tests++; if (wat_o !== 1'b1)   begin n_fail++; $display("FAIL wait_wat_after: got %b want 1", wat_o); end
        step();
        n_tests++; if (ack_o !== 1'b0)   begin n_fail++; $display("FAIL wait_ack_single: got %b want 0", ack_o); end
        cyc_i = 1'b0; stb_i = 1'b0;
    endtask

    task automatic test_write_err();
        push_word(32'h66);
        push_word(32'h77);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; dat_i = 32'hDEADBEEF;
        step();
        n_tests++; if (err_o !== 1'b1)       begin n_fail++; $display("FAIL wr_err: got %b want 1", err_o); end
        n_tests++; if (ack_o !== 1'b0)       begin n_fail++; $display("FAIL wr_ack: got %b want 0", ack_o); end
        stb_i = 1'b0; we_i = 1'b0;
        step();
        n_tests++; if (err_o !== 1'b0)       begin n_fail++; $display("FAIL wr_err_single: got %b want 0", err_o); end
        n_tests++; if (ack_o !== 1'b0)       begin n_fail++; $display("FAIL wr_ack_after: got %b want 0", ack_o); end
        n_tests++; if (dut.w_count !== 3'd2) begin n_fail++; $display("FAIL wr_count: got %0d want 2", dut.w_count); end
        n_tests++; if (dat_o !== 32'hA5)     begin n_fail++; $display("FAIL wr_dat_hold: got %h want a5", dat_o); end
        cyc_i = 1'b0;
    endtask

    task automatic test_full_push();
        logic [31:0] exp [4];
        exp = '{32'h77, 32'h88, 32'h99, 32'h55};
        push_word(32'h88);
        push_word(32'h99);
        n_tests++; if (s_ready_o !== 1'b0)   begin n_fail++; $display("FAIL full_ready: got %b want 0", s_ready_o); end
        s_valid_i = 1'b1; s_data_i = 32'h55;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0;
        step();
        n_tests++; if (ack_o !== 1'b1 || dat_o !== 32'h66) begin n_fail++; $display("FAIL full_pop: got ack=%b dat=%h want ack=1 dat=66", ack_o, dat_o); end
        n_tests++; if (s_ready_o !== 1'b1)   begin n_fail++; $display("FAIL full_ready_rise: got %b want 1", s_ready_o); end
        stb_i = 1'b0;
        step();
        s_valid_i = 1'b0;
        n_tests++; if (s_ready_o !== 1'b0)   begin n_fail++; $display("FAIL full_ready_refull: got %b want 0", s_ready_o); end
        n_tests++; if (dut.w_count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d want 4", dut.w_count); end
        stb_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            n_tests++; if (ack_o !== 1'b1 || dat_o !== exp[k]) begin n_fail++; $display("FAIL full_drain[%0d]: got ack=%b dat=%h want ack=1 dat=%h", k, ack_o, dat_o, exp[k]); end
        end
        stb_i = 1'b0;
        step();
        n_tests++; if (wat_o !== 1'b1)       begin n_fail++; $display("FAIL full_wat: got %b want 1", wat_o); end
        cyc_i = 1'b0;
    endtask

    task automatic test_suppress();
        push_word(32'h12);
        push_word(32'h34);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0;
        step();
        cyc_i = 1'b0; stb_i = 1'b0;
        #1;
        n_tests++; if (ack_o !== 1'b0)       begin n_fail++; $display("FAIL sup_ack: got %b want 0", ack_o); end
        n_tests++; if (dat_o !== 32'h55)     begin n_fail++; $display("FAIL sup_dat_hold: got %h want 55", dat_o); end
        step();
        n_tests++; if (dut.w_count !== 3'd1) begin n_fail++; $display("FAIL sup_count: got %0d want 1", dut.w_count); end
        cyc_i = 1'b1; stb_i = 1'b1;
        step();
        n_tests++; if (ack_o !== 1'b1 || dat_o !== 32'h34) begin n_fail++; $display("FAIL sup_next: got ack=%b dat=%h want ack=1 dat=34", ack_o, dat_o); end
        stb_i = 1'b0;
        step();
        cyc_i = 1'b0;
    endtask

    task automatic test_clear();
        push_word(32'hC1);
        push_word(32'hC2);
        push_word(32'hC3);
        clear_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0;
        step();
        n_tests++; if (ack_o !== 1'b1 || dat_o !== 32'hC1) begin n_fail++; $display("FAIL clr_ack: got ack=%b dat=%h want ack=1 dat=c1", ack_o, dat_o); end
        n_tests++; if (wat_o !== 1'b1)       begin n_fail++; $display("FAIL clr_wat: got %b want 1", wat_o); end
        n_tests++; if (dut.w_count !== 3'd0) begin n_fail++; $display("FAIL clr_count: got %0d want 0", dut.w_count); end
        n_tests++; if (s_ready_o !== 1'b1)   begin n_fail++; $display("FAIL clr_ready: got %b want 1", s_ready_o); end
        clear_i = 1'b0; stb_i = 1'b0;
        step();
        n_tests++; if (ack_o !== 1'b0)       begin n_fail++; $display("FAIL clr_ack_end: got %b want 0", ack_o); end
        cyc_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) push_word(32'hE1 + 32'(i));
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0;
        step();
        n_tests++; if (ack_o !== 1'b1 || dat_o !== 32'hE1) begin n_fail++; $display("FAIL rmid_ack: got ack=%b dat=%h want ack=1 dat=e1", ack_o, dat_o); end
        #2;
        rst_i = 1'b1;
        #1;
        n_tests++; if (ack_o !== 1'b0)     begin n_fail++; $display("FAIL rmid_ack_rst: got %b want 0", ack_o); end
        n_tests++; if (dat_o !== 32'h0)    begin n_fail++; $display("FAIL rmid_dat: got %h want 0", dat_o); end
        n_tests++; if (s_ready_o !== 1'b0) begin n_fail++; $display("FAIL rmid_ready: got %b want 0", s_ready_o); end
        n_tests++; if (wat_o !== 1'b1)     begin n_fail++; $display("FAIL rmid_wat: got %b want 1", wat_o); end
        n_tests++; if (err_o !== 1'b0)     begin n_fail++; $display("FAIL rmid_err: got %b want 0", err_o); end
        step();
        rst_i = 1'b0;
        step();
        n_tests++; if (s_ready_o !== 1'b1) begin n_fail++; $display("FAIL rmid_ready_rise: got %b want 1", s_ready_o); end
        n_tests++; if (wat_o !== 1'b1 || ack_o !== 1'b0) begin n_fail++; $display("FAIL rmid_quiet: got wat=%b ack=%b want wat=1 ack=0", wat_o, ack_o); end
        cyc_i = 1'b0; stb_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_burst();
        test_wait();
        test_write_err();
        test_full_push();
        test_suppress();
        test_clear();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
